// File: rtl/dfc_repeater.sv
// dfc_repeater: mid-path stage for a delayed-flow-control (DFC) link.
// Absorbs an upstream DFC stream into a FIFO and re-drives it downstream as a
// fresh DFC stream. This splits one long link into two shorter round trips.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   reset   - asynchronous, active-high reset
//   c_vld   - upstream word valid (one word per asserted cycle, no handshake)
//   c_data  - upstream word
//   c_fc_n  - flow control to upstream (1 = may send, 0 = stop), registered
//   p_vld   - downstream word valid, registered
//   p_data  - downstream word, registered (holds its value when p_vld = 0)
//   p_fc_n  - flow control from downstream (1 = may send, 0 = stop)
//   usage   - FIFO occupancy, 0..depth
//   ovf     - sticky overflow flag, cleared only by reset
module dfc_repeater #(
  parameter int unsigned width     = 8,
  parameter int unsigned depth     = 8,
  parameter int unsigned threshold = 4,
  parameter int unsigned asz       = $clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_vld,
  input  logic [width-1:0] c_data,
  output logic             c_fc_n,
  output logic             p_vld,
  output logic [width-1:0] p_data,
  input  logic             p_fc_n,
  output logic [asz:0]     usage,
  output logic             ovf
);

  localparam int unsigned UW = asz + 1;
  localparam logic [UW-1:0] DEPTH_U = UW'(depth);

  logic [width-1:0] mem [depth];
  logic [asz-1:0]   wr_ptr;
  logic [asz-1:0]   rd_ptr;

  logic             pop_c;
  logic             wr_c;
  logic             drop_c;
  logic [UW-1:0]    usage_next_c;
  logic             fc_next_c;

  // Pop/write decisions; full and empty come from usage only, never pointers.
  always_comb begin
    pop_c        = 1'b0;
    wr_c         = 1'b0;
    drop_c       = 1'b0;
    usage_next_c = usage;
    fc_next_c    = 1'b1;

    pop_c  = (usage != '0) && p_fc_n;
    // A full FIFO still accepts a word when a pop frees the head slot this cycle.
    wr_c   = c_vld && ((usage != DEPTH_U) || pop_c);
    drop_c = c_vld && !wr_c;

    usage_next_c = usage + UW'(wr_c) - UW'(pop_c);
    // Compare at 32 bits so depth - usage never wraps.
    fc_next_c    = (32'(depth) - 32'(usage_next_c)) > 32'(threshold);
  end

  // Storage array: contents need no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem[wr_ptr] <= c_data;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
      c_fc_n <= 1'b1;
      p_vld  <= 1'b0;
      p_data <= '0;
      ovf    <= 1'b0;
    end else begin
      usage  <= usage_next_c;
      c_fc_n <= fc_next_c;
      p_vld  <= pop_c;

      if (wr_c) begin
        wr_ptr <= wr_ptr + asz'(1);
      end

      // On a full write-with-pop, wr_ptr == rd_ptr; the head is read before
      // the array update takes effect, so ordering is preserved.
      if (pop_c) begin
        p_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + asz'(1);
      end

      if (drop_c) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dfc_repeater.sv
// Self-checking bench for dfc_repeater (width 8, depth 8, threshold 4).
module tb_dfc_repeater;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_vld;
  logic [7:0] c_data;
  logic       c_fc_n;
  logic       p_vld;
  logic [7:0] p_data;
  logic       p_fc_n;
  logic [3:0] usage;
  logic       ovf;

  int         n_vec = 0;
  int         n_err = 0;
  int         rx_cnt = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       pfc;
    logic       e_pv;
    logic [7:0] e_pd;
    logic [3:0] e_us;
    logic       e_cfc;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[14];

  dfc_repeater #(
    .width(8),
    .depth(8),
    .threshold(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .c_vld(c_vld),
    .c_data(c_data),
    .c_fc_n(c_fc_n),
    .p_vld(p_vld),
    .p_data(p_data),
    .p_fc_n(p_fc_n),
    .usage(usage),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock, sample #1 after the edge, and check output order.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (mon_en && p_vld) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %0h expected none", p_data);
      end else begin
        e = exp_q.pop_front();
        chk("order", 32'(p_data), 32'(e));
      end
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    c_vld  = 1'b0;
    c_data = 8'h00;
    p_fc_n = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    exp_q.delete();
    rx_cnt = 0;
  endtask

  initial begin
    int         first;
    int         maxu;
    bit         flag_fc;
    bit         flag_ovf;
    logic       fc_d1, fc_d2, v_d1, v_d2;
    int         cnt;
    bit         found;
    int         post;
    logic [31:0] cpat, ppat;
    int         sent;
    int         idx;

    // Reset state, checked while reset is still asserted
    reset  = 1'b1;
    c_vld  = 1'b0;
    c_data = 8'h00;
    p_fc_n = 1'b0;
    #1;
    chk("rst_p_vld", 32'(p_vld), 0);
    chk("rst_p_data", 32'(p_data), 0);
    chk("rst_c_fc_n", 32'(c_fc_n), 1);
    chk("rst_usage", 32'(usage), 0);
    chk("rst_ovf", 32'(ovf), 0);
    do_reset();

    // Table: {c_vld, c_data, p_fc_n} -> {p_vld, p_data, usage, c_fc_n, ovf}
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 4'd2, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 4'd3, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 4'd4, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 4'd3, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h22, 4'd3, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 4'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 4'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 4'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 4'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 4'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h66, 1'b1, 1'b0, 8'h55, 4'd1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h66, 4'd0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 4'd0, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      c_vld  = tbl[i].vld;
      c_data = tbl[i].d;
      p_fc_n = tbl[i].pfc;
      tick();
      chk($sformatf("v%0d_p_vld", i), 32'(p_vld), 32'(tbl[i].e_pv));
      chk($sformatf("v%0d_p_data", i), 32'(p_data), 32'(tbl[i].e_pd));
      chk($sformatf("v%0d_usage", i), 32'(usage), 32'(tbl[i].e_us));
      chk($sformatf("v%0d_c_fc_n", i), 32'(c_fc_n), 32'(tbl[i].e_cfc));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(tbl[i].e_ovf));
    end

    // A: 40-word stream, downstream always ready
    do_reset();
    mon_en   = 1'b1;
    first    = -1;
    maxu     = 0;
    flag_fc  = 1'b0;
    flag_ovf = 1'b0;
    for (int i = 0; i < 44; i++) begin
      c_vld  = (i < 40);
      c_data = 8'(i);
      p_fc_n = 1'b1;
      if (i < 40) exp_q.push_back(8'(i));
      tick();
      if (p_vld && first < 0) first = i;
      if (int'(usage) > maxu) maxu = int'(usage);
      if (!c_fc_n) flag_fc = 1'b1;
      if (ovf) flag_ovf = 1'b1;
    end
    chk("a_first_p_vld", 32'(first), 1);
    chk("a_usage_le2", 32'(maxu <= 2), 1);
    chk("a_fc_dropped", 32'(flag_fc), 0);
    chk("a_ovf", 32'(flag_ovf), 0);
    chk("a_rx_count", 32'(rx_cnt), 40);

    // B: downstream stalled, upstream reacts to c_fc_n with a 2+2 cycle link
    do_reset();
    fc_d1 = 1'b1; fc_d2 = 1'b1; v_d1 = 1'b0; v_d2 = 1'b0;
    cnt = 0; found = 1'b0; post = 0; maxu = 0;
    p_fc_n = 1'b0;
    for (int k = 0; k < 60 && post < 10; k++) begin
      c_vld = v_d2;
      if (v_d2) begin
        c_data = 8'(cnt);
        exp_q.push_back(8'(cnt));
        cnt++;
      end
      v_d2  = v_d1;
      v_d1  = fc_d2;
      fc_d2 = fc_d1;
      fc_d1 = c_fc_n;
      tick();
      if (int'(usage) > maxu) maxu = int'(usage);
      if (found) post++;
      else if (!c_fc_n) begin
        found = 1'b1;
        chk("b_usage_at_fc_fall", 32'(usage), 4);
      end
    end
    chk("b_fc_fell", 32'(found), 1);
    chk("b_usage_le8", 32'(maxu <= 8), 1);
    chk("b_ovf", 32'(ovf), 0);
    chk("b_fc_low", 32'(c_fc_n), 0);
    c_vld  = 1'b0;
    p_fc_n = 1'b1;
    repeat (12) tick();
    chk("b_drained", 32'(exp_q.size()), 0);
    chk("b_rx_count", 32'(rx_cnt), 32'(cnt));
    chk("b_usage_end", 32'(usage), 0);
    chk("b_fc_high", 32'(c_fc_n), 1);

    // C: forced overflow, 10 words into a stalled 8-entry FIFO
    do_reset();
    p_fc_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      c_vld  = 1'b1;
      c_data = 8'hA0 + 8'(i);
      if (i < 8) exp_q.push_back(8'hA0 + 8'(i));
      tick();
    end
    c_vld = 1'b0;
    chk("c_usage_full", 32'(usage), 8);
    chk("c_ovf_set", 32'(ovf), 1);
    p_fc_n = 1'b1;
    repeat (12) tick();
    chk("c_rx_count", 32'(rx_cnt), 8);
    chk("c_ovf_sticky", 32'(ovf), 1);
    chk("c_drained", 32'(exp_q.size()), 0);

    // D: full FIFO with simultaneous write and pop
    do_reset();
    p_fc_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c_vld  = 1'b1;
      c_data = 8'h30 + 8'(i);
      exp_q.push_back(8'h30 + 8'(i));
      tick();
    end
    chk("d_usage_full", 32'(usage), 8);
    chk("d_fc_low", 32'(c_fc_n), 0);
    for (int i = 0; i < 5; i++) begin
      c_vld  = 1'b1;
      c_data = 8'h40 + 8'(i);
      p_fc_n = 1'b1;
      exp_q.push_back(8'h40 + 8'(i));
      tick();
      chk($sformatf("d_usage_%0d", i), 32'(usage), 8);
      chk($sformatf("d_ovf_%0d", i), 32'(ovf), 0);
    end
    c_vld = 1'b0;
    repeat (12) tick();
    chk("d_rx_count", 32'(rx_cnt), 13);
    chk("d_drained", 32'(exp_q.size()), 0);

    // E: patterned traffic, 1000 words through a 2-cycle-delayed sender
    do_reset();
    cpat  = 32'h5A5A5A5A;
    ppat  = 32'hA5A5A5A5;
    fc_d1 = 1'b1;
    fc_d2 = 1'b1;
    sent  = 0;
    for (int cyc = 0; cyc < 6000 && rx_cnt < 1000; cyc++) begin
      idx    = cyc % 32;
      c_vld  = cpat[idx] && fc_d2 && (sent < 1000);
      if (c_vld) begin
        c_data = 8'(sent);
        exp_q.push_back(8'(sent));
        sent++;
      end
      p_fc_n = ppat[idx];
      fc_d2  = fc_d1;
      fc_d1  = c_fc_n;
      tick();
    end
    c_vld = 1'b0;
    chk("e_rx_count", 32'(rx_cnt), 1000);
    chk("e_ovf", 32'(ovf), 0);
    chk("e_drained", 32'(exp_q.size()), 0);

    // F: async reset mid-burst with usage 5, ovf set, p_vld high
    do_reset();
    p_fc_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      c_vld  = 1'b1;
      c_data = 8'hC0 + 8'(i);
      if (i < 8) exp_q.push_back(8'hC0 + 8'(i));
      tick();
    end
    c_vld  = 1'b0;
    p_fc_n = 1'b1;
    repeat (3) tick();
    chk("f_usage_pre", 32'(usage), 5);
    chk("f_p_vld_pre", 32'(p_vld), 1);
    chk("f_ovf_pre", 32'(ovf), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("f_p_vld_rst", 32'(p_vld), 0);
    chk("f_usage_rst", 32'(usage), 0);
    chk("f_ovf_rst", 32'(ovf), 0);
    chk("f_c_fc_n_rst", 32'(c_fc_n), 1);
    chk("f_p_data_rst", 32'(p_data), 0);
    exp_q.delete();
    #1;
    reset  = 1'b0;
    rx_cnt = 0;
    repeat (4) tick();
    chk("f_no_stale", 32'(rx_cnt), 0);
    c_vld  = 1'b1;
    c_data = 8'h77;
    exp_q.push_back(8'h77);
    tick();
    c_vld = 1'b0;
    repeat (3) tick();
    chk("f_fresh_word", 32'(rx_cnt), 1);
    chk("f_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dfc_repeater.md
Name: dfc_repeater

Overview:
- Mid-path stage for a delayed-flow-control (DFC) link.
- Consumes a DFC stream (vld/data in, fc_n out) into an internal FIFO and re-drives it as a fresh DFC stream (vld/data out, fc_n in).
- Sits between a dfc_sender and a dfc_receiver. It splits one long pipelined link into two shorter round-trip segments, each with its own skid budget.

Parameters:
- width, 8, data word width in bits.
- depth, 8, FIFO entries; power of two, minimum 4.
- threshold, 4, c_fc_n goes low when free entries are at or below this value. Must be at least the upstream round-trip in-flight word count.
- asz, $clog2(depth), FIFO pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- c_vld  input  1  upstream word valid; one word per asserted cycle, no handshake.
- c_data  input  width  upstream word.
- c_fc_n  output  1  to upstream; 1 = may send, 0 = stop sending.
- p_vld  output  1  downstream word valid, registered.
- p_data  output  width  downstream word, registered.
- p_fc_n  input  1  from downstream; 1 = may send, 0 = stop.
- usage  output  asz+1  current FIFO occupancy, 0..depth.
- ovf  output  1  sticky overflow error flag.

Behaviour:
- Reset (async assert, synchronous release):
  - p_vld=0, p_data=0, c_fc_n=1, usage=0, ovf=0.
  - Read and write pointers cleared.
  - Reset mid-stream discards all FIFO contents. No partial word is emitted.
- Write:
  - In any cycle with c_vld=1, c_data is written at the rising edge, provided usage<depth or a pop occurs in the same cycle.
  - Otherwise the word is dropped, ovf is set, and ovf holds until reset.
  - c_vld is accepted regardless of c_fc_n; words in flight after fc_n falls must be absorbed.
- Pop / send:
  - pop = (usage!=0) & p_fc_n, evaluated in the current cycle.
  - On pop, the head word is loaded into p_data, p_vld is 1 next cycle, and the read pointer advances.
  - If there is no pop, p_vld is 0 next cycle and p_data holds its last value.
  - p_fc_n is used directly as sampled; the downstream receiver budgets for its link delay.
- Latency:
  - A word written at edge N is in the FIFO from cycle N+1.
  - If p_fc_n=1 and the FIFO was empty, p_vld is asserted in cycle N+2.
  - Minimum cut-through is therefore 2 clocks.
- Occupancy:
  - usage_next = usage + write - pop. Simultaneous write and pop leaves usage unchanged.
  - Write-while-full with a pop is legal and is not an overflow.
- Flow control:
  - c_fc_n is registered: c_fc_n <= ((depth - usage_next) > threshold).
  - It falls the cycle after free space reaches threshold.
  - It rises the cycle after free space exceeds threshold. No extra hysteresis.
- Pointers wrap modulo depth. Full/empty are derived from usage only, never from pointer equality.
- Data ordering is strictly FIFO. No word is duplicated or reordered.
- p_fc_n=0 with an empty FIFO has no effect. p_fc_n toggling every cycle with a full FIFO gives a pop exactly on each p_fc_n=1 cycle.

Test Plan:
- Reset, then c_vld=1 for 40 cycles with incrementing data 0x00.., p_fc_n=1:
  - p_vld first high 2 cycles after the first c_vld.
  - Output is 40 words, 0x00..0x27 in order.
  - usage never exceeds 2; c_fc_n stays 1; ovf=0.
- p_fc_n held 0, c_vld=1 until c_fc_n falls, upstream modelled with 2+2 cycle link delay:
  - c_fc_n falls when usage reaches 4 (depth 8, threshold 4).
  - In-flight words land, giving usage ≤8 and ovf=0.
  - Release p_fc_n: all words drain in order, then c_fc_n returns to 1.
- Force overflow: p_fc_n=0, drive c_vld=1 for 10 cycles ignoring c_fc_n:
  - usage=8; words 9 and 10 are dropped.
  - ovf=1 and stays 1 after the drain.
  - Output is 8 words.
- Full FIFO with simultaneous write and pop (p_fc_n=1, c_vld=1, usage=8):
  - usage stays 8, ovf stays 0, data order is preserved.
- Random: c_vld pattern 0x5A5A5A5A, p_fc_n pattern 0xA5A5A5A5 through a 2-cycle-delayed sender, 1000 words:
  - A sequence checker reports 1000 ok, 0 errors; ovf=0.
- Async reset pulsed mid-burst with usage=5:
  - p_vld, usage and ovf go to 0 immediately.
  - c_fc_n goes to 1 immediately.
  - No stale word appears after release.
